// File: rtl/dino_game_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dino_game_sequencer - Dino Run game FSM, motion tick, speed ramp, scoring.
// Revision 1.0
// ---------------------------------------------------------------------------
module dino_game_sequencer #(
  parameter int TICK_CYCLES      = 2_000_000,
  parameter int PASSES_PER_LEVEL = 12,
  parameter int MAX_SPEED        = 8,
  parameter int DIE_CYCLES       = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        collision,
  input  logic        obstacle_passed,
  output logic        tick,
  output logic        run,
  output logic        game_over,
  output logic [1:0]  state,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic [1:0]  anim_phase,
  output logic        obs_reload
);

  localparam int TW = $clog2(TICK_CYCLES);
  localparam int DW = (DIE_CYCLES > 1) ? $clog2(DIE_CYCLES) : 1;
  localparam int PW = (PASSES_PER_LEVEL > 1) ? $clog2(PASSES_PER_LEVEL) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DIE_LAST  = DW'(DIE_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES_PER_LEVEL - 1);
  localparam logic [3:0]    SPEED_MAX = 4'(MAX_SPEED);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [DW-1:0]  die_cnt_q, die_cnt_d;
  logic [PW-1:0]  pass_cnt_q, pass_cnt_d;
  logic           start_q;
  logic           tick_q, tick_d;
  logic [3:0]     speed_q, speed_d;
  logic [15:0]    score_q, score_d;
  logic [15:0]    hi_score_q, hi_score_d;
  logic [1:0]     anim_q, anim_d;
  logic           reload_q, reload_d;
  logic           start_rise;

  assign start_rise = start_btn & ~start_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    die_cnt_d  = die_cnt_q;
    pass_cnt_d = pass_cnt_q;
    tick_d     = 1'b0;
    speed_d    = speed_q;
    score_d    = score_q;
    hi_score_d = hi_score_q;
    anim_d     = anim_q;
    reload_d   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (state_q == ST_IDLE) timer_d = '0;
        if (start_rise) begin
          state_d    = ST_RUN;
          reload_d   = 1'b1;
          score_d    = '0;
          speed_d    = 4'd1;
          pass_cnt_d = '0;
          timer_d    = '0;
          anim_d     = '0;
        end
      end

      ST_RUN: begin
        // A collision wins over everything else in the same cycle, including a pass.
        if (collision) begin
          state_d   = ST_DYING;
          die_cnt_d = '0;
        end else begin
          if (timer_q == TICK_LAST) begin
            timer_d = '0;
            tick_d  = 1'b1;
            anim_d  = anim_q + 2'd1;
          end else begin
            timer_d = timer_q + TW'(1);
          end

          if (obstacle_passed) begin
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
            if (pass_cnt_q == PASS_LAST) begin
              pass_cnt_d = '0;
              if (speed_q < SPEED_MAX) speed_d = speed_q + 4'd1;
            end else begin
              pass_cnt_d = pass_cnt_q + PW'(1);
            end
          end
        end
      end

      ST_DYING: begin
        if (die_cnt_q == DIE_LAST) begin
          state_d = ST_OVER;
          if (score_q > hi_score_q) hi_score_d = score_q;
        end else begin
          die_cnt_d = die_cnt_q + DW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      die_cnt_q  <= '0;
      pass_cnt_q <= '0;
      start_q    <= 1'b0;
      tick_q     <= 1'b0;
      speed_q    <= 4'd1;
      score_q    <= '0;
      hi_score_q <= '0;
      anim_q     <= '0;
      reload_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      die_cnt_q  <= die_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      start_q    <= start_btn;
      tick_q     <= tick_d;
      speed_q    <= speed_d;
      score_q    <= score_d;
      hi_score_q <= hi_score_d;
      anim_q     <= anim_d;
      reload_q   <= reload_d;
    end
  end

  assign tick       = tick_q;
  assign run        = (state_q == ST_RUN);
  assign game_over  = (state_q == ST_OVER);
  assign state      = state_q;
  assign speed      = speed_q;
  assign score      = score_q;
  assign hi_score   = hi_score_q;
  assign anim_phase = anim_q;
  assign obs_reload = reload_q;

endmodule
`default_nettype wire

// File: tb/tb_dino_game_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dino_game_sequencer - vector table, corner sequences and random model compare.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_dino_game_sequencer;

  localparam int TICK = 4;
  localparam int PPL  = 3;
  localparam int MAXS = 3;
  localparam int DIE  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_btn = 1'b0;
  logic        collision = 1'b0;
  logic        obstacle_passed = 1'b0;
  logic        tick, run, game_over, obs_reload;
  logic [1:0]  state, anim_phase;
  logic [3:0]  speed;
  logic [15:0] score, hi_score;

  int n_chk = 0;
  int n_err = 0;

  dino_game_sequencer #(
    .TICK_CYCLES(TICK), .PASSES_PER_LEVEL(PPL), .MAX_SPEED(MAXS), .DIE_CYCLES(DIE)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .collision(collision),
    .obstacle_passed(obstacle_passed), .tick(tick), .run(run), .game_over(game_over),
    .state(state), .speed(speed), .score(score), .hi_score(hi_score),
    .anim_phase(anim_phase), .obs_reload(obs_reload)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, st, col, pas;
    logic [1:0]  e_state;
    logic        e_tick, e_rel;
    logic [3:0]  e_spd;
    logic [15:0] e_sc, e_hi;
    logic [1:0]  e_an;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rst, logic st, logic col, logic pas, logic [1:0] es,
                              logic et, logic er, logic [3:0] ep, logic [15:0] esc,
                              logic [15:0] eh, logic [1:0] ea);
    tbl.push_back('{rst, st, col, pas, es, et, er, ep, esc, eh, ea});
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic [1:0] es, logic et, logic er, logic [3:0] ep,
                            logic [15:0] esc, logic [15:0] eh, logic [1:0] ea);
    chk({tag, "_state"}, 64'(state), 64'(es));
    chk({tag, "_run"}, 64'(run), 64'(es == 2'd1));
    chk({tag, "_over"}, 64'(game_over), 64'(es == 2'd3));
    chk({tag, "_tick"}, 64'(tick), 64'(et));
    chk({tag, "_reload"}, 64'(obs_reload), 64'(er));
    chk({tag, "_speed"}, 64'(speed), 64'(ep));
    chk({tag, "_score"}, 64'(score), 64'(esc));
    chk({tag, "_hi"}, 64'(hi_score), 64'(eh));
    chk({tag, "_anim"}, 64'(anim_phase), 64'(ea));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks game-level quantities (cycles since the game began, accepted
  // passes, ticks seen, time spent dying) and derives the outputs from them arithmetically.
  int m_state, m_age, m_passes, m_ticks, m_die, m_hi;
  bit m_prev, m_rel;

  function automatic int m_score();
    return (m_passes > 65535) ? 65535 : m_passes;
  endfunction

  function automatic int m_speed();
    int s = 1 + m_passes / PPL;
    return (s > MAXS) ? MAXS : s;
  endfunction

  task automatic m_reset();
    m_state = 0; m_age = 0; m_passes = 0; m_ticks = 0; m_die = 0; m_hi = 0;
    m_prev = 1'b0; m_rel = 1'b0;
  endtask

  task automatic m_step(bit rs, bit st, bit co, bit pa);
    bit rise = st && !m_prev;
    m_prev = st;
    m_rel  = 1'b0;
    if (rs) begin
      m_reset();
      return;
    end
    case (m_state)
      0, 3: if (rise) begin
        m_state = 1; m_age = 0; m_passes = 0; m_ticks = 0; m_rel = 1'b1;
      end
      1: if (co) begin
        m_state = 2; m_die = 0;
      end else begin
        m_age++;
        if (m_age % TICK == 0) m_ticks++;
        if (pa) m_passes++;
      end
      default: begin
        m_die++;
        if (m_die == DIE) begin
          m_state = 3;
          if (m_score() > m_hi) m_hi = m_score();
        end
      end
    endcase
  endtask

  initial begin
    // rst st col pas | state tick reload speed score hi anim
    add(1,0,0,0, 0,0,0,1,0,0,0);
    add(0,1,0,0, 1,0,1,1,0,0,0);
    add(0,1,0,0, 1,0,0,1,0,0,0);
    add(0,1,0,0, 1,0,0,1,0,0,0);
    add(0,1,0,0, 1,0,0,1,0,0,0);
    add(0,1,0,0, 1,1,0,1,0,0,1);
    add(0,1,0,1, 1,0,0,1,1,0,1);
    add(0,1,0,1, 1,0,0,1,2,0,1);
    add(0,1,0,1, 1,0,0,2,3,0,1);
    add(0,1,0,1, 1,1,0,2,4,0,2);
    add(0,1,0,1, 1,0,0,2,5,0,2);
    add(0,1,0,1, 1,0,0,3,6,0,2);
    add(0,1,0,1, 1,0,0,3,7,0,2);
    add(0,1,0,0, 1,1,0,3,7,0,3);
    add(0,1,0,1, 1,0,0,3,8,0,3);
    add(0,1,0,1, 1,0,0,3,9,0,3);
    add(0,1,0,0, 1,0,0,3,9,0,3);
    add(0,1,0,0, 1,1,0,3,9,0,0);
    add(0,1,1,1, 2,0,0,3,9,0,0);
    add(0,0,0,0, 2,0,0,3,9,0,0);
    add(0,0,0,0, 2,0,0,3,9,0,0);
    add(0,1,0,0, 2,0,0,3,9,0,0);
    add(0,1,0,1, 2,0,0,3,9,0,0);
    add(0,0,0,0, 3,0,0,3,9,9,0);
    add(0,1,0,0, 1,0,1,1,0,9,0);
    add(0,0,0,1, 1,0,0,1,1,9,0);
    add(0,0,1,0, 2,0,0,1,1,9,0);
    for (int k = 0; k < 4; k++) add(0,0,0,0, 2,0,0,1,1,9,0);
    add(0,0,0,0, 3,0,0,1,1,9,0);
    add(0,0,1,1, 3,0,0,1,1,9,0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; start_btn = tbl[i].st;
      collision = tbl[i].col; obstacle_passed = tbl[i].pas;
      step();
      check_outs($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_tick, tbl[i].e_rel,
                 tbl[i].e_spd, tbl[i].e_sc, tbl[i].e_hi, tbl[i].e_an);
    end

    // Restart from OVER, reach score 5 / speed 2, then reset mid-RUN.
    collision = 1'b0; obstacle_passed = 1'b0; start_btn = 1'b1;
    step();
    chk("restart_state", 64'(state), 64'd1);
    start_btn = 1'b0; obstacle_passed = 1'b1;
    for (int k = 0; k < 5; k++) step();
    obstacle_passed = 1'b0;
    chk("midrun_score", 64'(score), 64'd5);
    chk("midrun_speed", 64'(speed), 64'd2);
    chk("midrun_hi", 64'(hi_score), 64'd9);
    reset = 1'b1;
    step();
    check_outs("midreset", 2'd0, 1'b0, 1'b0, 4'd1, 16'd0, 16'd0, 2'd0);
    reset = 1'b0;

    // Score saturation: preload the score register, then keep passing.
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    force dut.score_q = 16'hFFFF;
    obstacle_passed = 1'b1;
    step();
    release dut.score_q;
    chk("sat_score0", 64'(score), 64'hFFFF);
    step();
    chk("sat_score1", 64'(score), 64'hFFFF);
    step();
    chk("sat_score2", 64'(score), 64'hFFFF);
    obstacle_passed = 1'b0;

    // Randomised run against the reference model.
    begin
      bit rs, st, co, pa;
      reset = 1'b1;
      step();
      m_reset();
      st = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        rs = ($urandom_range(0, 599) == 0);
        if ($urandom_range(0, 14) == 0) st = ~st;
        co = ($urandom_range(0, 29) == 0);
        pa = ($urandom_range(0, 2) == 0);
        reset = rs; start_btn = st; collision = co; obstacle_passed = pa;
        step();
        m_step(rs, st, co, pa);
        chk($sformatf("rnd%0d", c),
            {32'd0, state, tick, run, game_over, obs_reload, speed, score, anim_phase},
            {32'd0, 2'(m_state), (m_state == 1 && m_age > 0 && m_age % TICK == 0),
             (m_state == 1), (m_state == 3), m_rel, 4'(m_speed()), 16'(m_score()),
             2'(m_ticks % 4)});
        chk($sformatf("rnd%0d_hi", c), 64'(hi_score), 64'(m_hi));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
